// File: rtl/nn_pkg.sv
// Shared constants, state encoding and weight-map helpers for the
// two-neuron output layer of the feed-forward classifier.
package nn_pkg;

  localparam int NHID = 6;
  localparam int NOUT = 2;
  localparam int KW   = $clog2(NHID);

  localparam int DEF_WWIDTH = 8;
  localparam int DEF_ZWIDTH = 16;
  localparam int DEF_AWIDTH = 8;
  localparam int DEF_ASHIFT = 4;
  localparam int DEF_ACCW   = 20;

  localparam int W0_BASE = 0;
  localparam int W1_BASE = 6;
  localparam int B0_ADDR = 12;
  localparam int B1_ADDR = 13;

  typedef enum logic [2:0] {IDLE, ACT, MAC, BIAS, DONE} state_t;

  function automatic int weight_addr(input int n, input int i);
    return ((n == 0) ? W0_BASE : W1_BASE) + i;
  endfunction

  function automatic int bias_addr(input int n);
    return (n == 0) ? B0_ADDR : B1_ADDR;
  endfunction

endpackage

// File: rtl/nn_output_layer_if.sv
// Bundle of hidden inputs, weight-write port and result handshake
// between the first-layer stage, the output layer and its consumer.
interface nn_output_layer_if
  import nn_pkg::*;
#(
  parameter int ZWIDTH = DEF_ZWIDTH,
  parameter int WWIDTH = DEF_WWIDTH,
  parameter int ACCW   = DEF_ACCW
);

  logic signed [ZWIDTH-1:0] z0, z1, z2, z3, z4, z5;
  logic                     in_valid;
  logic                     in_ready;
  logic                     wr_en;
  logic        [3:0]        wr_addr;
  logic signed [WWIDTH-1:0] wr_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     y0, y1;
  logic signed [ACCW-1:0]   score0, score1;

  modport master (
    output z0, z1, z2, z3, z4, z5, in_valid, wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_valid, y0, y1, score0, score1
  );

  modport slave (
    input  z0, z1, z2, z3, z4, z5, in_valid, wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_valid, y0, y1, score0, score1
  );

endinterface

// File: rtl/nn_relu_sat.sv
// ReLU, arithmetic right shift and unsigned saturation of one hidden sum.
module nn_relu_sat #(
  parameter int ZWIDTH = 16,
  parameter int AWIDTH = 8,
  parameter int ASHIFT = 4
) (
  input  logic signed [ZWIDTH-1:0] z,
  output logic        [AWIDTH-1:0] a
);

  localparam logic [ZWIDTH-1:0] AMAX = ZWIDTH'((1 << AWIDTH) - 1);

  logic [ZWIDTH-1:0] shifted;

  always_comb begin
    shifted = z >>> ASHIFT;
    if (z[ZWIDTH-1]) begin
      a = '0;
    end else if (shifted > AMAX) begin
      a = '1;
    end else begin
      a = shifted[AWIDTH-1:0];
    end
  end

endmodule

// File: rtl/nn_output_layer.sv
// Output layer: activations from six hidden sums, serial MAC against two
// weight rows plus bias, class bits and scores over valid/ready.
module nn_output_layer
  import nn_pkg::*;
#(
  parameter int WWIDTH = DEF_WWIDTH,
  parameter int ZWIDTH = DEF_ZWIDTH,
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int ASHIFT = DEF_ASHIFT,
  parameter int ACCW   = DEF_ACCW
) (
  input logic              CLK,
  input logic              RST,
  nn_output_layer_if.slave io
);

  state_t state, state_nxt;

  logic signed [ZWIDTH-1:0]      z_in  [NHID];
  logic signed [ZWIDTH-1:0]      z_q   [NHID];
  logic        [AWIDTH-1:0]      a_nxt [NHID];
  logic        [AWIDTH-1:0]      a_q   [NHID];
  logic signed [WWIDTH-1:0]      w_q   [NOUT][NHID];
  logic signed [WWIDTH-1:0]      b_q   [NOUT];
  logic signed [ACCW-1:0]        acc_q [NOUT];
  logic signed [ACCW-1:0]        score_nxt [NOUT];
  logic signed [ACCW-1:0]        score_q   [NOUT];
  logic                          y_q   [NOUT];
  logic signed [AWIDTH+WWIDTH:0] prod  [NOUT];
  logic signed [AWIDTH:0]        a_ext;
  logic        [KW-1:0]          k;
  logic                          mac_last;

  always_comb begin
    z_in[0] = io.z0;
    z_in[1] = io.z1;
    z_in[2] = io.z2;
    z_in[3] = io.z3;
    z_in[4] = io.z4;
    z_in[5] = io.z5;
  end

  for (genvar i = 0; i < NHID; i++) begin : g_relu
    nn_relu_sat #(
      .ZWIDTH(ZWIDTH),
      .AWIDTH(AWIDTH),
      .ASHIFT(ASHIFT)
    ) u_relu (
      .z(z_q[i]),
      .a(a_nxt[i])
    );
  end

  // Activations are unsigned, so zero-extend before the signed multiply.
  always_comb begin
    a_ext    = $signed({1'b0, a_q[k]});
    mac_last = (k == KW'(NHID - 1));
    for (int n = 0; n < NOUT; n++) begin
      prod[n]      = a_ext * w_q[n][k];
      score_nxt[n] = acc_q[n] + ACCW'(b_q[n]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (io.in_valid) state_nxt = ACT;
      ACT:     state_nxt = MAC;
      MAC:     if (mac_last) state_nxt = BIAS;
      BIAS:    state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state == IDLE);
    io.out_valid = (state == DONE);
    io.y0        = y_q[0];
    io.y1        = y_q[1];
    io.score0    = score_q[0];
    io.score1    = score_q[1];
  end

  // Weight writes and input capture are only honoured while idle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      k <= '0;
      for (int i = 0; i < NHID; i++) begin
        z_q[i] <= '0;
        a_q[i] <= '0;
      end
      for (int n = 0; n < NOUT; n++) begin
        for (int i = 0; i < NHID; i++) begin
          w_q[n][i] <= '0;
        end
        b_q[n]     <= '0;
        acc_q[n]   <= '0;
        score_q[n] <= '0;
        y_q[n]     <= 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (io.wr_en) begin
            for (int n = 0; n < NOUT; n++) begin
              for (int i = 0; i < NHID; i++) begin
                if (io.wr_addr == 4'(weight_addr(n, i))) w_q[n][i] <= io.wr_data;
              end
              if (io.wr_addr == 4'(bias_addr(n))) b_q[n] <= io.wr_data;
            end
          end
          if (io.in_valid) begin
            for (int i = 0; i < NHID; i++) begin
              z_q[i] <= z_in[i];
            end
          end
        end
        ACT: begin
          k <= '0;
          for (int i = 0; i < NHID; i++) begin
            a_q[i] <= a_nxt[i];
          end
          for (int n = 0; n < NOUT; n++) begin
            acc_q[n] <= '0;
          end
        end
        MAC: begin
          k <= k + KW'(1);
          for (int n = 0; n < NOUT; n++) begin
            acc_q[n] <= acc_q[n] + ACCW'(prod[n]);
          end
        end
        BIAS: begin
          // A score of exactly zero is not a positive classification.
          for (int n = 0; n < NOUT; n++) begin
            score_q[n] <= score_nxt[n];
            y_q[n]     <= !score_nxt[n][ACCW-1] && (score_nxt[n] != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_output_layer.sv
// Self-checking bench: directed and randomized jobs against a cycle-level
// behavioural model of the output layer.
module tb_nn_output_layer;
  import nn_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  nn_output_layer_if io ();

  nn_output_layer dut (
    .CLK(CLK),
    .RST(RST),
    .io (io)
  );

  logic signed [15:0] zdrv [NHID];

  assign io.z0 = zdrv[0];
  assign io.z1 = zdrv[1];
  assign io.z2 = zdrv[2];
  assign io.z3 = zdrv[3];
  assign io.z4 = zdrv[4];
  assign io.z5 = zdrv[5];

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  int m_w0 [NHID];
  int m_w1 [NHID];
  int m_b0, m_b1;
  bit m_busy, m_valid;
  int m_count;
  int m_pend0, m_pend1, m_score0, m_score1;

  function automatic int activation(input int z);
    int a;
    if (z < 0) return 0;
    a = z / 16;
    return (a > 255) ? 255 : a;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: a job is accepted while idle, results appear 8 edges later.
  always @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NHID; i++) begin
        m_w0[i] = 0;
        m_w1[i] = 0;
      end
      m_b0 = 0; m_b1 = 0;
      m_busy = 1'b0; m_valid = 1'b0; m_count = 0;
      m_pend0 = 0; m_pend1 = 0; m_score0 = 0; m_score1 = 0;
    end else if (!m_busy) begin
      if (io.wr_en) begin
        for (int i = 0; i < NHID; i++) begin
          if (int'(io.wr_addr) == i)     m_w0[i] = int'(io.wr_data);
          if (int'(io.wr_addr) == i + 6) m_w1[i] = int'(io.wr_data);
        end
        if (io.wr_addr == 4'd12) m_b0 = int'(io.wr_data);
        if (io.wr_addr == 4'd13) m_b1 = int'(io.wr_data);
      end
      if (io.in_valid) begin
        m_busy  = 1'b1;
        m_count = 8;
        m_pend0 = m_b0;
        m_pend1 = m_b1;
        for (int i = 0; i < NHID; i++) begin
          m_pend0 += activation(int'(zdrv[i])) * m_w0[i];
          m_pend1 += activation(int'(zdrv[i])) * m_w1[i];
        end
      end
    end else if (!m_valid) begin
      m_count--;
      if (m_count == 0) begin
        m_valid  = 1'b1;
        m_score0 = m_pend0;
        m_score1 = m_pend1;
      end
    end else if (io.out_ready) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      checkOutput("cyc_in_ready", int'(io.in_ready), int'(!m_busy));
      checkOutput("cyc_out_valid", int'(io.out_valid), int'(m_valid));
      checkOutput("cyc_score0", io.score0, m_score0);
      checkOutput("cyc_score1", io.score1, m_score1);
      checkOutput("cyc_y0", int'(io.y0), int'(m_score0 > 0));
      checkOutput("cyc_y1", int'(io.y1), int'(m_score1 > 0));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic writeWeight(input int addr, input int data);
    io.wr_en   = 1'b1;
    io.wr_addr = 4'(addr);
    io.wr_data = 8'(data);
    @(negedge CLK);
    io.wr_en   = 1'b0;
  endtask

  task automatic setWeights(input int w0 [NHID], input int w1 [NHID], input int b0, input int b1);
    for (int i = 0; i < NHID; i++) begin
      writeWeight(W0_BASE + i, w0[i]);
      writeWeight(W1_BASE + i, w1[i]);
    end
    writeWeight(B0_ADDR, b0);
    writeWeight(B1_ADDR, b1);
  endtask

  task automatic applyStimulus(input int z [NHID]);
    for (int i = 0; i < NHID; i++) zdrv[i] = 16'(z[i]);
    io.in_valid = 1'b1;
    @(negedge CLK);
    io.in_valid = 1'b0;
  endtask

  task automatic waitValid(inout int lat);
    while (!io.out_valid && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    if (!io.out_valid) checkOutput("valid_timeout", int'(io.out_valid), 1);
  endtask

  task automatic releaseResult();
    io.out_ready = 1'b1;
    @(negedge CLK);
    io.out_ready = 1'b0;
    checkOutput("release_in_ready", int'(io.in_ready), 1);
    checkOutput("release_out_valid", int'(io.out_valid), 0);
  endtask

  task automatic runCase(input string tag, input int z [NHID], input int e0, input int e1,
                         input int y0, input int y1);
    int lat = 0;
    applyStimulus(z);
    waitValid(lat);
    checkOutput({tag, "_latency"}, lat, 8);
    checkOutput({tag, "_score0"}, io.score0, e0);
    checkOutput({tag, "_score1"}, io.score1, e1);
    checkOutput({tag, "_y0"}, int'(io.y0), y0);
    checkOutput({tag, "_y1"}, int'(io.y1), y1);
    releaseResult();
  endtask

  initial begin
    int z160 [NHID];
    int lat;
    for (int i = 0; i < NHID; i++) begin
      zdrv[i] = '0;
      z160[i] = 160;
    end
    io.in_valid = 1'b0; io.wr_en = 1'b0; io.wr_addr = '0; io.wr_data = '0;
    io.out_ready = 1'b0;

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_en = 1'b1;
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("reset_in_ready", int'(io.in_ready), 1);
    checkOutput("reset_out_valid", int'(io.out_valid), 0);
    checkOutput("reset_score0", io.score0, 0);
    checkOutput("reset_score1", io.score1, 0);
    checkOutput("reset_y0", int'(io.y0), 0);
    checkOutput("reset_y1", int'(io.y1), 0);

    setWeights('{1, 1, 1, 1, 1, 1}, '{-1, -1, -1, -1, -1, -1}, 0, 0);
    runCase("nominal", z160, 60, -60, 1, 0);

    setWeights('{2, 3, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}, 0, 0);
    runCase("saturate", '{32767, -256, 0, 0, 0, 0}, 510, 0, 1, 0);

    setWeights('{1, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0}, -10, 0);
    runCase("zero_score", '{160, 0, 0, 0, 0, 0}, 0, 0, 0, 0);
    writeWeight(B0_ADDR, -11);
    runCase("neg_score", '{160, 0, 0, 0, 0, 0}, -1, 0, 0, 0);

    setWeights('{1, 1, 1, 1, 1, 1}, '{-1, -1, -1, -1, -1, -1}, 0, 0);
    applyStimulus(z160);
    lat = 0;
    repeat (2) begin @(negedge CLK); lat++; end
    io.in_valid = 1'b1; io.wr_en = 1'b1; io.wr_addr = 4'd0; io.wr_data = 8'sd7;
    checkOutput("busy_in_ready", int'(io.in_ready), 0);
    repeat (2) begin @(negedge CLK); lat++; end
    io.in_valid = 1'b0; io.wr_en = 1'b0;
    waitValid(lat);
    checkOutput("backpressure_latency", lat, 8);
    repeat (5) begin
      @(negedge CLK);
      checkOutput("hold_out_valid", int'(io.out_valid), 1);
      checkOutput("hold_score0", io.score0, 60);
      checkOutput("hold_score1", io.score1, -60);
      checkOutput("hold_in_ready", int'(io.in_ready), 0);
    end
    releaseResult();
    runCase("rerun", z160, 60, -60, 1, 0);

    applyStimulus(z160);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (12) begin
      @(negedge CLK);
      checkOutput("abort_out_valid", int'(io.out_valid), 0);
    end
    checkOutput("abort_in_ready", int'(io.in_ready), 1);
    runCase("after_reset", z160, 0, 0, 0, 0);

    for (int it = 0; it < 30; it++) begin
      int nw;
      int ng;
      int mode;
      int zr [NHID];
      nw = $urandom_range(0, 6);
      for (int j = 0; j < nw; j++) writeWeight($urandom_range(0, 15), $urandom_range(0, 255) - 128);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < NHID; i++) begin
        case (mode)
          0:       zr[i] = $urandom_range(0, 65535) - 32768;
          1:       zr[i] = $urandom_range(0, 4500) - 300;
          default: zr[i] = 16 * $urandom_range(0, 300);
        endcase
      end
      applyStimulus(zr);
      lat = 0;
      ng = $urandom_range(0, 5);
      for (int g = 0; g < ng; g++) begin
        io.in_valid = 1'($urandom_range(0, 1));
        io.wr_en    = 1'($urandom_range(0, 1));
        io.wr_addr  = 4'($urandom_range(0, 15));
        io.wr_data  = 8'($urandom);
        @(negedge CLK);
        lat++;
      end
      io.in_valid = 1'b0; io.wr_en = 1'b0;
      waitValid(lat);
      checkOutput("rand_latency", lat, 8);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      releaseResult();
    end

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
